// File: rtl/data_memory_split.sv
// Byte-addressed little-endian data memory built from four interleaved byte lanes.
// Accesses that straddle a word boundary take a second beat through the SPLIT state.
module data_memory_split #(
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = ""
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_Req,
    input  logic        i_Wen,
    input  logic [1:0]  i_Size,
    input  logic        i_Unsigned,
    input  logic [31:0] i_Addr,
    input  logic [31:0] i_Wd,
    output logic [31:0] o_Rd,
    output logic        o_Ready,
    output logic        o_Valid,
    output logic        o_Err
);

    localparam int AW = $clog2(DEPTH / 4);

    typedef enum logic {IDLE, SPLIT} state_t;

    // Lane b of entry e is byte 4*e+b, so the flat array is the four banks interleaved.
    logic [7:0] r_mem [DEPTH];

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW+1:0] r_addr;
    logic [2:0]    r_nbytes;
    logic [1:0]    r_size;
    logic          r_uns;
    logic          r_wen;
    logic [31:0]   r_wd;
    logic [31:0]   r_lo;
    logic [31:0]   r_rd;
    logic          r_valid;
    logic          r_err;

    logic          w_accept;
    logic [2:0]    w_nbytes;
    logic [32:0]   w_last;
    logic          w_err;
    logic          w_cross;

    logic [1:0]    w_off;
    logic [2:0]    w_n;
    logic [AW-1:0] w_entry;
    logic [31:0]   w_wd;
    logic          w_wen;
    logic [1:0]    w_size;
    logic          w_uns;
    logic          w_active;
    logic          w_beat2;

    logic [1:0]    w_k [4];
    logic [3:0]    w_we;
    logic [7:0]    w_wbyte [4];
    logic [31:0]   w_rword;
    logic [63:0]   w_pair;
    logic [63:0]   w_shift;
    logic [31:0]   w_raw;
    logic [31:0]   w_ext;

    assign o_Ready  = (r_state == IDLE);
    assign o_Valid  = r_valid;
    assign o_Err    = r_err;
    assign o_Rd     = r_rd;

    assign w_accept = i_Req && (r_state == IDLE) && i_rst_n;

    always_comb begin
        case (i_Size)
            2'b00:   w_nbytes = 3'd1;
            2'b01:   w_nbytes = 3'd2;
            2'b10:   w_nbytes = 3'd4;
            default: w_nbytes = 3'd1;
        endcase
    end

    // Range check is done in 33 bits so addresses near 2^32 cannot wrap into range.
    assign w_last  = {1'b0, i_Addr} + 33'(w_nbytes) - 33'd1;
    assign w_err   = (i_Size == 2'b11) || (w_last >= 33'(DEPTH));
    assign w_cross = ({2'b00, i_Addr[1:0]} + {1'b0, w_nbytes}) > 4'd4;

    // Current beat: either a fresh request from the ports or the second half of a split.
    always_comb begin
        w_off    = i_Addr[1:0];
        w_n      = w_nbytes;
        w_entry  = i_Addr[AW+1:2];
        w_wd     = i_Wd;
        w_wen    = i_Wen;
        w_size   = i_Size;
        w_uns    = i_Unsigned;
        w_active = w_accept && !w_err;
        w_beat2  = 1'b0;
        if (r_state == SPLIT) begin
            w_off    = r_addr[1:0];
            w_n      = r_nbytes;
            w_entry  = r_addr[AW+1:2] + AW'(1);
            w_wd     = r_wd;
            w_wen    = r_wen;
            w_size   = r_size;
            w_uns    = r_uns;
            w_active = 1'b1;
            w_beat2  = 1'b1;
        end
    end

    // Lane b holds access byte k = b - offset; beat 1 owns lanes at/above the offset.
    always_comb begin
        w_we    = '0;
        w_rword = '0;
        for (int b = 0; b < 4; b++) begin
            w_k[b]     = 2'(b) - w_off;
            w_we[b]    = w_active && w_wen &&
                         (w_beat2 ? (2'(b) < w_off) : (2'(b) >= w_off)) &&
                         ({1'b0, w_k[b]} < w_n);
            w_wbyte[b] = w_wd[8*w_k[b] +: 8];
            w_rword[8*b +: 8] = r_mem[{w_entry, 2'(b)}];
        end
    end

    assign w_pair  = w_beat2 ? {w_rword, r_lo} : {32'd0, w_rword};
    assign w_shift = w_pair >> {w_off, 3'b000};
    assign w_raw   = w_shift[31:0];

    always_comb begin
        case (w_size)
            2'b00:   w_ext = w_uns ? {24'd0, w_raw[7:0]}  : {{24{w_raw[7]}}, w_raw[7:0]};
            2'b01:   w_ext = w_uns ? {16'd0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
            default: w_ext = w_raw;
        endcase
    end

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_we[b]) r_mem[{w_entry, 2'(b)}] <= w_wbyte[b];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_err && w_cross) w_state_nxt = SPLIT;
            SPLIT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_nbytes <= '0;
            r_size   <= '0;
            r_uns    <= 1'b0;
            r_wen    <= 1'b0;
            r_wd     <= '0;
            r_lo     <= '0;
            r_rd     <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= 1'b0;
            if (r_state == SPLIT) begin
                r_valid <= 1'b1;
                r_err   <= 1'b0;
                r_rd    <= r_wen ? 32'd0 : w_ext;
            end else if (w_accept) begin
                if (w_err) begin
                    r_valid <= 1'b1;
                    r_err   <= 1'b1;
                    r_rd    <= '0;
                end else if (w_cross) begin
                    r_addr   <= i_Addr[AW+1:0];
                    r_nbytes <= w_nbytes;
                    r_size   <= i_Size;
                    r_uns    <= i_Unsigned;
                    r_wen    <= i_Wen;
                    r_wd     <= i_Wd;
                    r_lo     <= w_rword;
                end else begin
                    r_valid <= 1'b1;
                    r_err   <= 1'b0;
                    r_rd    <= i_Wen ? 32'd0 : w_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_split.sv
// Directed bench for data_memory_split: vector table plus hand-written split/reset sequences.
module tb_data_memory_split;

    logic        clk;
    logic        rst_n;
    logic        i_Req;
    logic        i_Wen;
    logic [1:0]  i_Size;
    logic        i_Unsigned;
    logic [31:0] i_Addr;
    logic [31:0] i_Wd;
    logic [31:0] o_Rd;
    logic        o_Ready;
    logic        o_Valid;
    logic        o_Err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    data_memory_split #(.DEPTH(1024), .INIT_FILE("")) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_Req      (i_Req),
        .i_Wen      (i_Wen),
        .i_Size     (i_Size),
        .i_Unsigned (i_Unsigned),
        .i_Addr     (i_Addr),
        .i_Wd       (i_Wd),
        .o_Rd       (o_Rd),
        .o_Ready    (o_Ready),
        .o_Valid    (o_Valid),
        .o_Err      (o_Err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wen, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        vec_t v;
        v.wen = wen; v.size = size; v.uns = uns; v.addr = addr; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    // One request; waits up to 4 cycles for o_Valid and reports the cycle it appeared in.
    task automatic access(input logic wen, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat,
                          output logic rdy_mid);
        @(negedge clk);
        i_Wen = wen; i_Size = size; i_Unsigned = uns; i_Addr = addr; i_Wd = wd; i_Req = 1'b1;
        @(posedge clk);
        #1 i_Req = 1'b0;
        lat = -1; rd = '0; err = 1'b0; rdy_mid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) rdy_mid = o_Ready;
            if (o_Valid) begin
                lat = c; rd = o_Rd; err = o_Err;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic        rdy_mid;
        logic        seen;

        rst_n = 1'b1; i_Req = 1'b0; i_Wen = 1'b0; i_Size = 2'b00; i_Unsigned = 1'b0;
        i_Addr = '0; i_Wd = '0;
        #2 rst_n = 1'b0;
        #2;
        check("reset_ready", 32'(o_Ready), 32'd1);
        check("reset_valid", 32'(o_Valid), 32'd0);
        check("reset_err",   32'(o_Err),   32'd0);
        check("reset_rd",    o_Rd,         32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Preload bytes 00..FF at addresses 0..255.
        for (int i = 0; i < 64; i++) begin
            access(1'b1, 2'b10, 1'b0, 32'(4*i),
                   {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, rd, err, lat, rdy_mid);
            check($sformatf("preload%0d_lat", i), 32'(lat), 32'd1);
        end

        vecs.push_back(mk(0, 2'b10, 0, 32'h04,  0,            32'h07060504, 0, 1));
        vecs.push_back(mk(0, 2'b00, 0, 32'h80,  0,            32'hFFFFFF80, 0, 1));
        vecs.push_back(mk(0, 2'b00, 1, 32'h80,  0,            32'h00000080, 0, 1));
        vecs.push_back(mk(0, 2'b01, 0, 32'h81,  0,            32'hFFFF8281, 0, 1));
        vecs.push_back(mk(0, 2'b01, 1, 32'h83,  0,            32'h00008483, 0, 2));
        vecs.push_back(mk(0, 2'b01, 0, 32'h86,  0,            32'hFFFF8786, 0, 1));
        vecs.push_back(mk(0, 2'b00, 0, 32'h05,  0,            32'h00000005, 0, 1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h41,  0,            32'h44434241, 0, 2));
        vecs.push_back(mk(1, 2'b10, 0, 32'h0E,  32'hDEADBEEF, 32'h0,        0, 2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0C,  0,            32'hBEEF0D0C, 0, 1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10,  0,            32'h1312DEAD, 0, 1));
        vecs.push_back(mk(1, 2'b01, 0, 32'h21,  32'h0000A5A5, 32'h0,        0, 1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h20,  0,            32'h23A5A520, 0, 1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h3FE, 0,            32'h0,        1, 1));
        vecs.push_back(mk(0, 2'b11, 0, 32'h30,  0,            32'h0,        1, 1));
        vecs.push_back(mk(1, 2'b11, 0, 32'h30,  32'hFFFFFFFF, 32'h0,        1, 1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h30,  0,            32'h33323130, 0, 1));
        vecs.push_back(mk(1, 2'b00, 0, 32'h3FF, 32'h0000007F, 32'h0,        0, 1));
        vecs.push_back(mk(1, 2'b10, 0, 32'h3FE, 32'hFFFFFFFF, 32'h0,        1, 1));
        vecs.push_back(mk(0, 2'b00, 0, 32'h3FF, 0,            32'h0000007F, 0, 1));
        vecs.push_back(mk(0, 2'b01, 0, 32'h3FF, 0,            32'h0,        1, 1));

        foreach (vecs[i]) begin
            access(vecs[i].wen, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                   rd, err, lat, rdy_mid);
            check($sformatf("vec%0d_rd", i),    rd,          vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i),   32'(err),    32'(vecs[i].exp_err));
            check($sformatf("vec%0d_lat", i),   32'(lat),    32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_ready", i), 32'(rdy_mid), 32'(vecs[i].exp_lat == 1));
        end

        // o_Rd holds while o_Valid is low.
        access(0, 2'b10, 0, 32'h08, 0, rd, err, lat, rdy_mid);
        repeat (3) @(negedge clk);
        check("hold_valid", 32'(o_Valid), 32'd0);
        check("hold_rd",    o_Rd,         32'h0B0A0908);

        // Back-to-back aligned reads, one per cycle.
        @(negedge clk);
        i_Wen = 1'b0; i_Size = 2'b10; i_Unsigned = 1'b0; i_Addr = 32'h04; i_Req = 1'b1;
        @(posedge clk);
        #1 i_Addr = 32'h08;
        @(negedge clk);
        check("b2b_valid0", 32'(o_Valid), 32'd1);
        check("b2b_rd0",    o_Rd,         32'h07060504);
        @(posedge clk);
        #1 i_Req = 1'b0;
        @(negedge clk);
        check("b2b_valid1", 32'(o_Valid), 32'd1);
        check("b2b_rd1",    o_Rd,         32'h0B0A0908);

        // Split read with port inputs changed during SPLIT: captured values must be used.
        @(negedge clk);
        i_Wen = 1'b0; i_Size = 2'b10; i_Unsigned = 1'b0; i_Addr = 32'h45; i_Req = 1'b1;
        @(posedge clk);
        #1 i_Addr = 32'h00; i_Wen = 1'b1; i_Wd = 32'hCAFEF00D;
        @(negedge clk);
        check("split_in_ready", 32'(o_Ready), 32'd0);
        check("split_in_valid", 32'(o_Valid), 32'd0);
        @(posedge clk);
        #1 i_Req = 1'b0; i_Wen = 1'b0;
        @(negedge clk);
        check("split_in_valid2", 32'(o_Valid), 32'd1);
        check("split_in_rd",     o_Rd,         32'h48474645);
        access(0, 2'b10, 0, 32'h00, 0, rd, err, lat, rdy_mid);
        check("split_in_mem0", rd, 32'h03020100);

        // Reset in the SPLIT cycle of a word write at 0x3F: beat 2 abandoned, no completion.
        @(negedge clk);
        i_Wen = 1'b1; i_Size = 2'b10; i_Unsigned = 1'b0; i_Addr = 32'h3F; i_Wd = 32'h11223344;
        i_Req = 1'b1;
        @(posedge clk);
        #1 i_Req = 1'b0; rst_n = 1'b0;
        #1;
        check("rst_split_ready", 32'(o_Ready), 32'd1);
        check("rst_split_valid", 32'(o_Valid), 32'd0);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (o_Valid) seen = 1'b1;
        end
        check("rst_split_novalid", 32'(seen), 32'd0);
        access(0, 2'b00, 1, 32'h3F, 0, rd, err, lat, rdy_mid);
        check("rst_split_b3f", rd, 32'h00000044);
        access(0, 2'b10, 0, 32'h40, 0, rd, err, lat, rdy_mid);
        check("rst_split_w40", rd, 32'h43424140);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
